master_addr_tx: RTL and testbench
=================================

# master_addr_tx

Master-side serial request transmitter for the system bus. It accepts a parallel request (full address, read/write, write data) and shifts the device-address field onto the serial address line. It then waits for the address decoder's acknowledge and shifts out the memory address, plus write data on writes. It is the sending end of the serial address/acknowledge link that the bus address decoder receives.

## Interface
Parameters:
- ADDR_WIDTH, 16, full request address width; device field is the top DEVICE_ADDR_WIDTH bits.
- DEVICE_ADDR_WIDTH, 4, device-address field width; must equal the decoder's value.
- DATA_WIDTH, 8, write-data width.
- ACK_TIMEOUT, 8, cycles to wait for ack before aborting (1..255).

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_addr  in  ADDR_WIDTH  target address.
- req_wen  in  1  1 = write (data phase sent), 0 = read.
- req_wdata  in  DATA_WIDTH  write data.
- ack  in  1  decoder acknowledge: device address received and slave ready.
- addr_valid  out  1  serial line qualifier.
- addr_data  out  1  serial bit, LSB first.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse: payload fully sent.
- err  out  1  one-cycle pulse: ack timeout, request aborted.

## Operation
- Derived widths: MEM_W = ADDR_WIDTH-DEVICE_ADDR_WIDTH. PAY_LEN = MEM_W+DATA_WIDTH if write, else MEM_W. The bit counter is wide enough for MEM_W+DATA_WIDTH.
- States are IDLE, DEV_ADDR, WAIT_ACK and PAYLOAD.
- IDLE:
  - req_ready = 1 only in IDLE and only while ack = 0. This blocks a stale ack from a previous transaction.
  - On req_valid & req_ready: latch req_addr, req_wen and req_wdata; clear the counter; go to DEV_ADDR.
- DEV_ADDR:
  - addr_valid = 1; addr_data = device-field bit[cnt], LSB first.
  - Lasts exactly DEVICE_ADDR_WIDTH consecutive cycles, then WAIT_ACK.
  - ack is ignored in this state.
- WAIT_ACK:
  - addr_valid = 0; wait counter increments each cycle.
  - ack sampled 1: go to PAYLOAD, clear counter.
  - Else, wait count reaching ACK_TIMEOUT: pulse err, go to IDLE.
  - The decoder drops an invalid or busy slave silently, so timeout is the only failure indication.
- PAYLOAD:
  - addr_valid = 1 for PAY_LEN consecutive cycles.
  - Bits 0..MEM_W-1 are memory-address bits, LSB first. Next (write only): req_wdata bits, LSB first.
  - After the last bit: pulse done, go to IDLE.
  - ack level is ignored during PAYLOAD.
- addr_data = 0 whenever addr_valid = 0.
- busy = 1 in every state except IDLE.
- All outputs are registered except req_ready, which is decoded from state and ack.

## Timing
- Reset values: addr_valid 0, addr_data 0, busy 0, done 0, err 0; state IDLE; counters 0. req_ready follows ack after reset.
- Accept at edge T → first device bit valid in cycle T+1 → last device bit in cycle T+DEVICE_ADDR_WIDTH.
- addr_valid never has a gap inside a phase. There is always at least one addr_valid-low cycle between the device and payload phases, so the decoder sees a fresh rise.
- Ack at the earliest WAIT_ACK cycle W → first payload bit in W+1.
- done is asserted in the cycle after the last payload bit, when addr_valid is already 0. A new request can be accepted in that same cycle if ack = 0.
- Timeout: err is asserted ACK_TIMEOUT cycles after WAIT_ACK entry if ack stays low. An ack arriving in the same cycle as timeout expiry wins: no err.
- Reset asserted mid-transaction: outputs return to reset values immediately (asynchronously) and the latched request is discarded. No done or err is produced.
- req_* inputs are don't-care outside the accept cycle.

## Test plan
- Write 0x20A5, data 0x3C (defaults), ack 2 cycles after last device bit:
  - addr_valid high 4 cycles, bits 0,1,0,0.
  - Then a gap.
  - Then 20 payload bits: 0x0A5 LSB first, then 0x3C LSB first.
  - done once; busy low after.
- Read 0x1123, ack immediate:
  - Device bits 1,0,0,0.
  - 12-bit payload 0x123.
  - No data bits; done pulses.
- Timeout: request 0xF000, ack held 0.
  - err pulses 8 cycles after WAIT_ACK entry.
  - No payload; addr_valid stays 0; back in IDLE.
- Ack pulsed during DEV_ADDR only, then low → ignored, err after timeout.
- Stale ack held high in IDLE with req_valid = 1 → req_ready = 0, no transmission. Ack drop → accept next cycle.
- Reset asserted on the 5th payload bit → addr_valid, busy, done, err all 0 immediately. Next request transmits correctly from bit 0.

Source files
------------

// File: rtl/master_addr_tx.sv
// Serial request transmitter: device field, wait for ack, then memory address (+ write data), LSB first.
// First serial bit one cycle after accept; req_ready only in IDLE with ack low; ack timeout aborts with err.
module master_addr_tx #(
   parameter int ADDR_WIDTH        = 16,
   parameter int DEVICE_ADDR_WIDTH = 4,
   parameter int DATA_WIDTH        = 8,
   parameter int ACK_TIMEOUT       = 8
)(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_wen,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic                  ack,
   output logic                  addr_valid,
   output logic                  addr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int MEM_W   = ADDR_WIDTH - DEVICE_ADDR_WIDTH;
   localparam int PAY_W   = MEM_W + DATA_WIDTH;
   localparam int MAX_AD  = (ACK_TIMEOUT > DEVICE_ADDR_WIDTH) ? ACK_TIMEOUT : DEVICE_ADDR_WIDTH;
   localparam int CNT_MAX = (PAY_W > MAX_AD) ? PAY_W : MAX_AD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] DEV_LAST = CNT_W'(DEVICE_ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEV_ADDR,
      S_WAIT_ACK,
      S_PAYLOAD
   } state_t;

   state_t                       r_state;
   logic [CNT_W-1:0]             r_cnt;
   logic                         r_wen;
   logic [DEVICE_ADDR_WIDTH-1:0] r_dev;
   logic [PAY_W-1:0]             r_pay;
   logic                         r_addr_valid;
   logic                         r_addr_data;
   logic                         r_busy;
   logic                         r_done;
   logic                         r_err;

   logic                         w_accept;
   logic [DEVICE_ADDR_WIDTH-1:0] w_req_dev;
   logic [CNT_W-1:0]             w_pay_last;

   // A held ack in IDLE is left over from the previous transaction; refuse new work until it drops.
   assign req_ready  = (r_state == S_IDLE) && !ack;
   assign w_accept   = req_valid && req_ready;
   assign w_req_dev  = req_addr[ADDR_WIDTH-1 -: DEVICE_ADDR_WIDTH];
   assign w_pay_last = r_wen ? CNT_W'(PAY_W - 1) : CNT_W'(MEM_W - 1);

   assign addr_valid = r_addr_valid;
   assign addr_data  = r_addr_data;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;

   // Shift registers hold the bits not yet presented; the output register always shows the current bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_wen        <= 1'b0;
         r_dev        <= '0;
         r_pay        <= '0;
         r_addr_valid <= 1'b0;
         r_addr_data  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state      <= S_DEV_ADDR;
                  r_cnt        <= '0;
                  r_wen        <= req_wen;
                  r_dev        <= w_req_dev >> 1;
                  r_pay        <= {req_wdata, req_addr[MEM_W-1:0]};
                  r_addr_valid <= 1'b1;
                  r_addr_data  <= w_req_dev[0];
                  r_busy       <= 1'b1;
               end
            end
            S_DEV_ADDR: begin
               if (r_cnt == DEV_LAST) begin
                  r_state      <= S_WAIT_ACK;
                  r_cnt        <= '0;
                  r_addr_valid <= 1'b0;
                  r_addr_data  <= 1'b0;
               end else begin
                  r_cnt       <= r_cnt + 1'b1;
                  r_addr_data <= r_dev[0];
                  r_dev       <= r_dev >> 1;
               end
            end
            S_WAIT_ACK: begin
               // ack is checked first so an ack on the expiry cycle still wins
               if (ack) begin
                  r_state      <= S_PAYLOAD;
                  r_cnt        <= '0;
                  r_addr_valid <= 1'b1;
                  r_addr_data  <= r_pay[0];
                  r_pay        <= r_pay >> 1;
               end else if (r_cnt == TO_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_PAYLOAD: begin
               if (r_cnt == w_pay_last) begin
                  r_state      <= S_IDLE;
                  r_cnt        <= '0;
                  r_addr_valid <= 1'b0;
                  r_addr_data  <= 1'b0;
                  r_done       <= 1'b1;
                  r_busy       <= 1'b0;
               end else begin
                  r_cnt       <= r_cnt + 1'b1;
                  r_addr_data <= r_pay[0];
                  r_pay       <= r_pay >> 1;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_cnt        <= '0;
               r_addr_valid <= 1'b0;
               r_addr_data  <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_master_addr_tx.sv
// Bench for master_addr_tx: serial bits checked against a queue filled when each request is driven,
// per-cycle control outputs checked against the timeline derived from the request shape.
module tb_master_addr_tx;

   localparam int AW  = 16;
   localparam int DEV = 4;
   localparam int DW  = 8;
   localparam int TO  = 8;
   localparam int MEM = AW - DEV;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          req_wen = 1'b0;
   logic [DW-1:0] req_wdata = '0;
   logic          ack = 1'b0;
   logic          addr_valid;
   logic          addr_data;
   logic          busy;
   logic          done;
   logic          err;

   int   n_checks = 0;
   int   n_errors = 0;
   logic exp_bits[$];
   logic mon_exp;
   bit   mon_en = 1'b0;

   master_addr_tx #(
      .ADDR_WIDTH(AW),
      .DEVICE_ADDR_WIDTH(DEV),
      .DATA_WIDTH(DW),
      .ACK_TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .req_wen(req_wen),
      .req_wdata(req_wdata),
      .ack(ack),
      .addr_valid(addr_valid),
      .addr_data(addr_data),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog sim time exceeded");
      $fatal(1, "watchdog");
   end

   // Serial line monitor: every valid bit must match the next queued bit; data must be 0 when not valid.
   always @(negedge clk) begin
      if (mon_en && rstn) begin
         n_checks++;
         if (addr_valid) begin
            if (exp_bits.size() == 0) begin
               n_errors++;
               $display("FAIL bit_unexpected got %0b want no bit", addr_data);
            end else begin
               mon_exp = exp_bits.pop_front();
               if (addr_data !== mon_exp) begin
                  n_errors++;
                  $display("FAIL serial_bit got %0b want %0b at %0t", addr_data, mon_exp, $time);
               end
            end
         end else if (addr_data !== 1'b0) begin
            n_errors++;
            $display("FAIL data_idle got %0b want 0 at %0t", addr_data, $time);
         end
      end
   end

   // Drives one request at the current negedge and checks every cycle up to done/err (or the abort point).
   // d: WAIT_ACK cycles before ack (-1 = never ack). abort_k: cycle at which reset is asserted (0 = none).
   task automatic run_txn(input logic [AW-1:0] addr, input logic wen, input logic [DW-1:0] wdata,
                          input int d, input bit ack_dev, input int abort_k);
      int pay, pay_s, pay_e, nat_end, k_end;
      logic [MEM+DW-1:0] pl;
      logic exp_v, exp_bz, exp_dn, exp_er;
      pay     = wen ? MEM + DW : MEM;
      pay_s   = DEV + 2 + d;
      pay_e   = pay_s + pay - 1;
      nat_end = (d < 0) ? DEV + 1 + TO : pay_e + 1;
      k_end   = (abort_k > 0) ? abort_k : nat_end;
      for (int i = 0; i < DEV; i++) exp_bits.push_back(addr[MEM + i]);
      if (d >= 0) begin
         pl = {wdata, addr[MEM-1:0]};
         for (int i = 0; i < pay; i++) exp_bits.push_back(pl[i]);
      end
      req_valid = 1'b1;
      req_addr  = addr;
      req_wen   = wen;
      req_wdata = wdata;
      ack       = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL req_ready_accept got %0b want 1", req_ready);
      end
      for (int k = 1; k <= k_end; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req_valid = 1'b0;
            req_addr  = AW'($urandom);
            req_wen   = 1'($urandom);
            req_wdata = DW'($urandom);
         end
         exp_v  = (k <= DEV) || (d >= 0 && k >= pay_s && k <= pay_e);
         exp_bz = (k < nat_end);
         exp_dn = (d >= 0 && k == pay_e + 1);
         exp_er = (d < 0 && k == nat_end);
         n_checks += 4;
         if (addr_valid !== exp_v) begin
            n_errors++;
            $display("FAIL addr_valid cyc %0d got %0b want %0b", k, addr_valid, exp_v);
         end
         if (busy !== exp_bz) begin
            n_errors++;
            $display("FAIL busy cyc %0d got %0b want %0b", k, busy, exp_bz);
         end
         if (done !== exp_dn) begin
            n_errors++;
            $display("FAIL done cyc %0d got %0b want %0b", k, done, exp_dn);
         end
         if (err !== exp_er) begin
            n_errors++;
            $display("FAIL err cyc %0d got %0b want %0b", k, err, exp_er);
         end
         ack = (d >= 0 && k == DEV + 1 + d) || (ack_dev && k == 2);
      end
      if (abort_k > 0) begin
         #1 rstn = 1'b0;
         #1;
         n_checks++;
         if ({addr_valid, addr_data, busy, done, err} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_mid outputs got %b want 00000", {addr_valid, addr_data, busy, done, err});
         end
         exp_bits.delete();
         ack = 1'b0;
         @(negedge clk);
         rstn = 1'b1;
      end else begin
         n_checks++;
         if (exp_bits.size() != 0) begin
            n_errors++;
            $display("FAIL bits_left got %0d want 0", exp_bits.size());
            exp_bits.delete();
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      ack  = 1'b0;
      #2;
      n_checks += 2;
      if ({addr_valid, addr_data, busy, done, err} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_outputs got %b want 00000", {addr_valid, addr_data, busy, done, err});
      end
      if (req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_ready_ack0 got %0b want 1", req_ready);
      end
      ack = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ready_ack1 got %0b want 0", req_ready);
      end
      ack = 1'b0;
      repeat (2) @(negedge clk);
      rstn   = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_write();
      run_txn(16'h20A5, 1'b1, 8'h3C, 1, 1'b0, 0);
   endtask

   task automatic test_back_to_back_read();
      run_txn(16'h1123, 1'b0, 8'h00, 0, 1'b0, 0);
   endtask

   task automatic test_timeout();
      run_txn(16'hF000, 1'b0, 8'h00, -1, 1'b0, 0);
   endtask

   task automatic test_ack_in_dev();
      run_txn(16'h5ABC, 1'b1, 8'h99, -1, 1'b1, 0);
   endtask

   task automatic test_stale_ack();
      ack       = 1'b1;
      req_valid = 1'b1;
      req_addr  = 16'h3456;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks += 3;
         if (req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL stale_ready cyc %0d got %0b want 0", c, req_ready);
         end
         if (addr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stale_valid cyc %0d got %0b want 0", c, addr_valid);
         end
         if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stale_busy cyc %0d got %0b want 0", c, busy);
         end
      end
      run_txn(16'h3456, 1'b1, 8'hE7, 2, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      run_txn(16'h20A5, 1'b1, 8'h3C, 0, 1'b0, DEV + 2 + 4);
      run_txn(16'h7C21, 1'b1, 8'h5A, 0, 1'b0, 0);
   endtask

   task automatic test_end();
      @(negedge clk);
      n_checks++;
      if ({busy, done, err, addr_valid} !== 4'b0) begin
         n_errors++;
         $display("FAIL end_idle got %b want 0000", {busy, done, err, addr_valid});
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_back_to_back_read();
      test_timeout();
      test_ack_in_dev();
      test_stale_ack();
      test_reset_mid();
      test_end();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
